// File: rtl/hd_muxb_sync.sv
`default_nettype none
// ============================================================================
// Module      : hd_muxb_sync
// Description : Registered N:1 data multiplexer with runtime-selectable output
//               polarity and a guarded valid/ready select-change handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module hd_muxb_sync #(
    parameter  int WIDTH  = 1,
    parameter  int NUM_IN = 2,
    parameter  int GUARD  = 2,
    localparam int SELW   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    CK,
    input  logic                    RN,
    input  logic [NUM_IN*WIDTH-1:0] A,
    input  logic                    INV,
    input  logic [SELW-1:0]         SEL_REQ,
    input  logic                    SEL_VLD,
    output logic                    SEL_RDY,
    output logic                    SEL_ERR,
    output logic [SELW-1:0]         SEL_CUR,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        Z
);

    localparam int            c_ndec   = 1 << SELW;
    localparam logic [SELW:0] c_num_in = (SELW + 1)'(NUM_IN);
    localparam logic [3:0]    c_guard  = 4'(GUARD);

    typedef enum logic [0:0] {
        S_LOCK = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [SELW-1:0]  r_pend;
    logic [SELW-1:0]  w_pend_nxt;
    logic [SELW-1:0]  r_cur;
    logic [SELW-1:0]  w_cur_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] w_z_nxt;

    logic [WIDTH-1:0] w_a [0:c_ndec-1];
    logic [WIDTH-1:0] w_sel_data;
    logic             w_req_ok;

    // Decode table padded to a power of two so any select value indexes safely.
    genvar gi;
    generate
        for (gi = 0; gi < c_ndec; gi++) begin : g_unpack
            if (gi < NUM_IN) begin : g_used
                assign w_a[gi] = A[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_a[gi] = '0;
            end
        end
    endgenerate

    assign w_sel_data = w_a[r_cur];
    // An unknown request makes this compare unknown, which falls to the error branch.
    assign w_req_ok   = ({1'b0, SEL_REQ} < c_num_in);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_cur_nxt   = r_cur;
        w_err_nxt   = 1'b0;
        w_z_nxt     = r_z;
        case (r_state)
            S_LOCK: begin
                w_z_nxt = INV ? ~w_sel_data : w_sel_data;
                if (SEL_VLD) begin
                    if (w_req_ok) begin
                        if (SEL_REQ != r_cur) begin
                            w_pend_nxt  = SEL_REQ;
                            w_cnt_nxt   = c_guard;
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_cur_nxt   = r_pend;
                    w_state_nxt = S_LOCK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_LOCK;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_LOCK;
            r_cnt   <= 4'd0;
            r_pend  <= '0;
            r_cur   <= '0;
            r_err   <= 1'b0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_cur   <= w_cur_nxt;
            r_err   <= w_err_nxt;
            r_z     <= w_z_nxt;
        end
    end

    assign SEL_RDY = (r_state == S_LOCK);
    assign BUSY    = (r_state == S_HOLD);
    assign SEL_ERR = r_err;
    assign SEL_CUR = r_cur;
    assign Z       = r_z;

endmodule
`default_nettype wire

// File: tb/tb_hd_muxb_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_hd_muxb_sync
// Description : Self-checking bench for hd_muxb_sync (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hd_muxb_sync;

    logic        clk;
    logic        rn;

    // u0: WIDTH=4, NUM_IN=4, GUARD=2
    logic [15:0] a0;
    logic        inv0;
    logic [1:0]  req0;
    logic        vld0;
    logic        rdy0, err0, busy0;
    logic [1:0]  cur0;
    logic [3:0]  z0;

    // u1: WIDTH=4, NUM_IN=3, GUARD=0
    logic [11:0] a1;
    logic        inv1;
    logic [1:0]  req1;
    logic        vld1;
    logic        rdy1, err1, busy1;
    logic [1:0]  cur1;
    logic [3:0]  z1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] a;
        logic        inv;
        logic [3:0]  exp;
    } vec_t;

    vec_t       tbl [6];
    logic [3:0] sb_q [$];
    logic [3:0] exp_z;

    hd_muxb_sync #(.WIDTH(4), .NUM_IN(4), .GUARD(2)) u0 (
        .CK(clk), .RN(rn), .A(a0), .INV(inv0), .SEL_REQ(req0), .SEL_VLD(vld0),
        .SEL_RDY(rdy0), .SEL_ERR(err0), .SEL_CUR(cur0), .BUSY(busy0), .Z(z0)
    );

    hd_muxb_sync #(.WIDTH(4), .NUM_IN(3), .GUARD(0)) u1 (
        .CK(clk), .RN(rn), .A(a1), .INV(inv1), .SEL_REQ(req1), .SEL_VLD(vld1),
        .SEL_RDY(rdy1), .SEL_ERR(err1), .SEL_CUR(cur1), .BUSY(busy1), .Z(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{16'h8421, 1'b0, 4'h1};
        tbl[1] = '{16'h8421, 1'b1, 4'hE};
        tbl[2] = '{16'hFFF0, 1'b0, 4'h0};
        tbl[3] = '{16'h000F, 1'b1, 4'h0};
        tbl[4] = '{16'h5A3C, 1'b0, 4'hC};
        tbl[5] = '{16'h5A3C, 1'b1, 4'h3};

        rn = 1'b0;
        a0 = 16'h8421; inv0 = 1'b1; req0 = 2'd0; vld0 = 1'b0;
        a1 = 12'hCA5;  inv1 = 1'b0; req1 = 2'd0; vld1 = 1'b0;
        step(); step();

        chk("rst_z",    32'(z0),    32'h0);
        chk("rst_cur",  32'(cur0),  32'h0);
        chk("rst_rdy",  32'(rdy0),  32'h1);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_err",  32'(err0),  32'h0);
        chk("rst_z1",   32'(z1),    32'h0);

        rn = 1'b1;
        step();
        chk("rel_z_inv", 32'(z0), 32'hE);
        chk("rel_z1",    32'(z1), 32'h5);
        inv0 = 1'b0;
        step();
        chk("rel_z_true", 32'(z0), 32'h1);

        // Table-driven LOCK vectors with SEL_CUR = 0 through the scoreboard
        for (int i = 0; i < 6; i++) begin
            a0   = tbl[i].a;
            inv0 = tbl[i].inv;
            sb_q.push_back(tbl[i].exp);
            step();
            exp_z = sb_q.pop_front();
            chk($sformatf("tbl_z[%0d]", i), 32'(z0), 32'(exp_z));
        end

        // Select change to input 2, with stimulus churn during HOLD
        a0 = 16'h8421; inv0 = 1'b0;
        step();
        chk("pre_sel_z", 32'(z0), 32'h1);
        req0 = 2'd2; vld0 = 1'b1;
        step();
        chk("h1_busy", 32'(busy0), 32'h1);
        chk("h1_rdy",  32'(rdy0),  32'h0);
        chk("h1_z",    32'(z0),    32'h1);
        chk("h1_cur",  32'(cur0),  32'h0);
        a0 = 16'hFFFF; inv0 = 1'b1; req0 = 2'd3; vld0 = 1'b1;
        step();
        chk("h2_busy", 32'(busy0), 32'h1);
        chk("h2_z",    32'(z0),    32'h1);
        chk("h2_err",  32'(err0),  32'h0);
        vld0 = 1'b0; a0 = 16'h8421; inv0 = 1'b0;
        step();
        chk("h3_busy", 32'(busy0), 32'h1);
        chk("h3_z",    32'(z0),    32'h1);
        chk("h3_err",  32'(err0),  32'h0);
        step();
        chk("exit_busy", 32'(busy0), 32'h0);
        chk("exit_rdy",  32'(rdy0),  32'h1);
        chk("exit_cur",  32'(cur0),  32'h2);
        chk("exit_z",    32'(z0),    32'h1);
        step();
        chk("new_z", 32'(z0), 32'h4);

        // Same-index request is a no-op
        req0 = 2'd2; vld0 = 1'b1;
        step();
        vld0 = 1'b0;
        chk("noop_busy", 32'(busy0), 32'h0);
        chk("noop_err",  32'(err0),  32'h0);
        chk("noop_cur",  32'(cur0),  32'h2);
        step();
        chk("noop_busy2", 32'(busy0), 32'h0);

        // Reset asserted on the second HOLD cycle
        req0 = 2'd1; vld0 = 1'b1;
        step();
        vld0 = 1'b0;
        step();
        chk("mh_busy", 32'(busy0), 32'h1);
        chk("mh_z",    32'(z0),    32'h4);
        rn = 1'b0;
        #1;
        chk("mh_rst_z",    32'(z0),    32'h0);
        chk("mh_rst_cur",  32'(cur0),  32'h0);
        chk("mh_rst_busy", 32'(busy0), 32'h0);
        chk("mh_rst_rdy",  32'(rdy0),  32'h1);
        step(); step();
        rn = 1'b1;
        step();
        chk("mh_rel_z",    32'(z0),    32'h1);
        chk("mh_rel_cur",  32'(cur0),  32'h0);
        chk("mh_rel_busy", 32'(busy0), 32'h0);
        step();
        chk("mh_rel_cur2", 32'(cur0),  32'h0);

        // u1: out-of-range request
        req1 = 2'd3; vld1 = 1'b1;
        step();
        vld1 = 1'b0;
        chk("err_pulse", 32'(err1),  32'h1);
        chk("err_cur",   32'(cur1),  32'h0);
        chk("err_busy",  32'(busy1), 32'h0);
        chk("err_z",     32'(z1),    32'h5);
        step();
        chk("err_clear", 32'(err1),  32'h0);
        chk("err_busy2", 32'(busy1), 32'h0);

        // u1: back-to-back requests 1 then 2 with GUARD=0
        req1 = 2'd1; vld1 = 1'b1;
        step();
        chk("b2b_h1_busy", 32'(busy1), 32'h1);
        chk("b2b_h1_z",    32'(z1),    32'h5);
        req1 = 2'd2;
        step();
        chk("b2b_x1_cur",  32'(cur1),  32'h1);
        chk("b2b_x1_rdy",  32'(rdy1),  32'h1);
        chk("b2b_x1_z",    32'(z1),    32'h5);
        step();
        vld1 = 1'b0;
        chk("b2b_h2_busy", 32'(busy1), 32'h1);
        chk("b2b_h2_z",    32'(z1),    32'hA);
        chk("b2b_h2_cur",  32'(cur1),  32'h1);
        step();
        chk("b2b_x2_cur",  32'(cur1),  32'h2);
        chk("b2b_x2_busy", 32'(busy1), 32'h0);
        chk("b2b_x2_z",    32'(z1),    32'hA);
        step();
        chk("b2b_new_z",   32'(z1),    32'hC);
        chk("b2b_err",     32'(err1),  32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
